pll_reset_seq: RTL

- Parametrised PLL bring-up and supervision sequencer; next generation of the fixed HS-clock PLL wrapper.
- Drives a GTP_PLL_E1 instance's RST and RSTODIV_PHASE inputs and monitors its LOCK output.
- Issues staggered per-output-channel resets, retries failed locks up to a limit, detects loss of lock in operation and relocks automatically.
- Runs on the free-running PLL reference clock; sits between board reset logic and the PLL wrapper in the MIPI/video clocking path.

---
 rtl/pll_reset_seq.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/pll_reset_seq.sv
// PLL bring-up and supervision sequencer: drives PLL RST / RSTODIV_PHASE, qualifies LOCK,
// releases staggered per-channel resets, retries failed locks and relocks on loss of lock.
module pll_reset_seq #(
    parameter int NUM_OUT          = 3,
    parameter int RST_HOLD_CYC     = 16,
    parameter int LOCK_STABLE_CYC  = 256,
    parameter int LOCK_TIMEOUT_CYC = 65535,
    parameter int RSTODIV_CYC      = 8,
    parameter int STAGGER_CYC      = 4,
    parameter int MAX_RETRY        = 3,
    parameter int LOSS_FILT_CYC    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pll_lock,
    input  logic               restart,
    output logic               pll_rst,
    output logic               rstodiv,
    output logic [NUM_OUT-1:0] out_rst_n,
    output logic               ready,
    output logic               fault,
    output logic [3:0]         retry_cnt,
    output logic [7:0]         lock_lost_cnt
);

    localparam int HOLD_W = $clog2(RST_HOLD_CYC + 1);
    localparam int STAB_W = $clog2(LOCK_STABLE_CYC + 1);
    localparam int TO_W   = $clog2(LOCK_TIMEOUT_CYC + 1);
    localparam int ODIV_W = $clog2(RSTODIV_CYC + 1);
    localparam int REL_CYC = STAGGER_CYC * NUM_OUT;
    localparam int REL_W  = $clog2(REL_CYC + 1);
    localparam int FILT_W = $clog2(LOSS_FILT_CYC + 1);

    typedef enum logic [2:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_ODIV_ALIGN,
        S_RELEASE,
        S_RUN,
        S_FAULT
    } state_e;

    state_e state, state_nxt;

    logic              lock_meta, lock_s;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic [STAB_W-1:0] stable_cnt, stable_nxt;
    logic [TO_W-1:0]   timeout_cnt, timeout_nxt;
    logic [ODIV_W-1:0] odiv_cnt, odiv_nxt;
    logic [REL_W-1:0]  rel_cnt, rel_nxt, rel_inc;
    logic [FILT_W-1:0] filt_cnt, filt_nxt;

    logic               pll_rst_nxt, rstodiv_nxt, ready_nxt, fault_nxt;
    logic [NUM_OUT-1:0] out_rst_n_nxt;
    logic [3:0]         retry_nxt;
    logic [7:0]         lost_nxt;
    logic               loss;

    // pll_lock comes from the PLL's own analogue loop, so it is resynchronised before use.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep each flop sampling the pre-edge value.
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_RESET_PLL;
            hold_cnt      <= '0;
            stable_cnt    <= '0;
            timeout_cnt   <= '0;
            odiv_cnt      <= '0;
            rel_cnt       <= '0;
            filt_cnt      <= '0;
            pll_rst       <= 1'b1;
            rstodiv       <= 1'b1;
            out_rst_n     <= '0;
            ready         <= 1'b0;
            fault         <= 1'b0;
            retry_cnt     <= '0;
            lock_lost_cnt <= '0;
        end else begin
            state         <= state_nxt;
            hold_cnt      <= hold_nxt;
            stable_cnt    <= stable_nxt;
            timeout_cnt   <= timeout_nxt;
            odiv_cnt      <= odiv_nxt;
            rel_cnt       <= rel_nxt;
            filt_cnt      <= filt_nxt;
            pll_rst       <= pll_rst_nxt;
            rstodiv       <= rstodiv_nxt;
            out_rst_n     <= out_rst_n_nxt;
            ready         <= ready_nxt;
            fault         <= fault_nxt;
            retry_cnt     <= retry_nxt;
            lock_lost_cnt <= lost_nxt;
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_nxt     = state;
        hold_nxt      = '0;
        stable_nxt    = '0;
        timeout_nxt   = '0;
        odiv_nxt      = '0;
        rel_nxt       = '0;
        filt_nxt      = '0;
        pll_rst_nxt   = 1'b1;
        rstodiv_nxt   = 1'b1;
        out_rst_n_nxt = '0;
        ready_nxt     = 1'b0;
        fault_nxt     = 1'b0;
        retry_nxt     = retry_cnt;
        lost_nxt      = lock_lost_cnt;
        rel_inc       = rel_cnt + 1'b1;
        loss          = !lock_s && (filt_cnt == FILT_W'(LOSS_FILT_CYC - 1));

        if (restart) begin
            state_nxt = S_RESET_PLL;
            retry_nxt = '0;
        end else begin
            case (state)
                S_RESET_PLL: begin
                    if (hold_cnt == HOLD_W'(RST_HOLD_CYC - 1)) begin
                        state_nxt   = S_WAIT_LOCK;
                        pll_rst_nxt = 1'b0;
                    end else begin
                        hold_nxt = hold_cnt + 1'b1;
                    end
                end
                S_WAIT_LOCK: begin
                    // A lock qualifying on the timeout cycle still counts as a lock.
                    if (lock_s && (stable_cnt == STAB_W'(LOCK_STABLE_CYC - 1))) begin
                        state_nxt   = S_ODIV_ALIGN;
                        pll_rst_nxt = 1'b0;
                    end else if (timeout_cnt == TO_W'(LOCK_TIMEOUT_CYC - 1)) begin
                        if (retry_cnt == 4'(MAX_RETRY)) begin
                            state_nxt = S_FAULT;
                            fault_nxt = 1'b1;
                        end else begin
                            state_nxt = S_RESET_PLL;
                            retry_nxt = retry_cnt + 4'd1;
                        end
                    end else begin
                        pll_rst_nxt = 1'b0;
                        stable_nxt  = lock_s ? stable_cnt + 1'b1 : '0;
                        timeout_nxt = timeout_cnt + 1'b1;
                    end
                end
                S_ODIV_ALIGN: begin
                    pll_rst_nxt = 1'b0;
                    if (odiv_cnt == ODIV_W'(RSTODIV_CYC - 1)) begin
                        state_nxt   = S_RELEASE;
                        rstodiv_nxt = 1'b0;
                    end else begin
                        odiv_nxt = odiv_cnt + 1'b1;
                    end
                end
                S_RELEASE, S_RUN: begin
                    if (loss) begin
                        state_nxt = S_RESET_PLL;
                        if (lock_lost_cnt != 8'hFF) lost_nxt = lock_lost_cnt + 8'd1;
                    end else begin
                        pll_rst_nxt = 1'b0;
                        rstodiv_nxt = 1'b0;
                        filt_nxt    = lock_s ? '0 : filt_cnt + 1'b1;
                        if (state == S_RUN) begin
                            out_rst_n_nxt = '1;
                            ready_nxt     = 1'b1;
                        end else begin
                            rel_nxt = rel_inc;
                            for (int i = 0; i < NUM_OUT; i++)
                                out_rst_n_nxt[i] = (rel_inc >= REL_W'(STAGGER_CYC * (i + 1)));
                            if (rel_inc == REL_W'(REL_CYC)) begin
                                state_nxt = S_RUN;
                                ready_nxt = 1'b1;
                                retry_nxt = '0;
                                rel_nxt   = '0;
                            end
                        end
                    end
                end
                S_FAULT: begin
                    fault_nxt = 1'b1;
                end
                default: begin
                    state_nxt = S_RESET_PLL;
                end
            endcase
        end
    end

endmodule
